wb_ctrl: RTL

- Write-back controller; the producer end of the register-file write port (regwrite / wa / wd / memtoreg).
- Accepts one retiring instruction from execute. For loads, it fetches the data memory word. It then drives exactly one write pulse into the register file.
- Sits between the execute stage, data memory read port and the register file.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_ctrl_if.sv | 46 ++++
 rtl/wb_ctrl_timeout_ctr.sv | 26 ++
 rtl/wb_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back controller.
package wb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    WRITE    = 2'd2
  } state_t;

endpackage

// File: rtl/wb_ctrl_if.sv
// Execute / memory-read / register-file port bundle of wb_ctrl.
// The controller is the slave of the execute handshake.
interface wb_ctrl_if #(
  parameter int DATA_W = wb_pkg::DATA_W_DEF,
  parameter int ADDR_W = wb_pkg::ADDR_W_DEF
);

  logic              ex_valid;
  logic              ex_ready;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic [ADDR_W-1:0] ex_wa;
  logic [DATA_W-1:0] ex_alu;

  logic              mem_rd_req;
  logic [DATA_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;

  logic              regwrite;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              memtoreg;
  logic              err_timeout;

  modport slave (
    input  ex_valid, ex_regwrite,
    input  ex_memtoreg, ex_wa, ex_alu,
    input  mem_rd_valid, mem_rd_data,
    output ex_ready,
    output mem_rd_req, mem_rd_addr,
    output regwrite, wa, wd, memtoreg,
    output err_timeout
  );

  modport master (
    output ex_valid, ex_regwrite,
    output ex_memtoreg, ex_wa, ex_alu,
    output mem_rd_valid, mem_rd_data,
    input  ex_ready,
    input  mem_rd_req, mem_rd_addr,
    input  regwrite, wa, wd, memtoreg,
    input  err_timeout
  );

endinterface

// File: rtl/wb_ctrl_timeout_ctr.sv
// Saturating up-counter with clear/enable; expired when cnt == LIMIT.
module wb_timeout_ctr #(
  parameter int W     = 4,
  parameter int LIMIT = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         expired
);

  assign expired = (cnt == W'(LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: one register-file write per retired instruction.
// Optional WB_STALL_CNT_EN adds a saturating MEM_WAIT cycle counter.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef WB_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  wb_ctrl_if.slave    bus
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            next;
  logic              ready;
  logic              take;
  logic              in_wait;
  logic              got;
  logic              abort;
  logic              tmo_exp;
  logic [TW-1:0]     tmo_cnt;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] addr_q;
  logic              mtr_q;
  logic              req_q;
  logic              err_q;

  assign ready   = (state == IDLE);
  assign in_wait = (state == MEM_WAIT);
  assign take    = bus.ex_valid && ready && bus.ex_regwrite;
  assign got     = in_wait && bus.mem_rd_valid;
  // data arriving on the last allowed cycle beats the timeout
  assign abort   = in_wait && tmo_exp && !bus.mem_rd_valid;

  // counter holds k-1 in the k-th wait cycle
  wb_timeout_ctr #(
    .W     (TW),
    .LIMIT (MEM_TIMEOUT - 1)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_wait),
    .en      (in_wait),
    .cnt     (tmo_cnt),
    .expired (tmo_exp)
  );

`ifdef WB_STALL_CNT_EN
  logic stall_full;

  wb_timeout_ctr #(
    .W     (16),
    .LIMIT (16'hFFFF)
  ) u_stall (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (1'b0),
    .en      (in_wait && !stall_full),
    .cnt     (stall_cnt),
    .expired (stall_full)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (take) begin
          next = bus.ex_memtoreg ? MEM_WAIT : WRITE;
        end
      end
      MEM_WAIT: begin
        if (got || abort) begin
          next = WRITE;
        end
      end
      WRITE:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_q   <= '0;
      wd_q   <= '0;
      addr_q <= '0;
      mtr_q  <= 1'b0;
      req_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        take: begin
          wa_q <= bus.ex_wa;
          if (bus.ex_memtoreg) begin
            addr_q <= bus.ex_alu;
            req_q  <= 1'b1;
          end else begin
            wd_q  <= bus.ex_alu;
            mtr_q <= 1'b0;
          end
        end
        got: begin
          wd_q  <= bus.mem_rd_data;
          mtr_q <= 1'b1;
          req_q <= 1'b0;
        end
        abort: begin
          wd_q  <= '0;
          mtr_q <= 1'b1;
          err_q <= 1'b1;
          req_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ex_ready    = ready;
  assign bus.mem_rd_req  = req_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.regwrite    = (state == WRITE) &&
                           (wa_q != ADDR_W'(ZERO_REG));
  assign bus.wa          = wa_q;
  assign bus.wd          = wd_q;
  assign bus.memtoreg    = mtr_q;
  assign bus.err_timeout = err_q;

endmodule
